md_sched: RTL

//   Multi-cycle scheduler for the E-stage multiply/divide resource of the pipelined CPU.
//   - Accepts one HI/LO operation per issue and models the fixed multiply/divide latency.
//   - Owns the architectural HI/LO registers.
//   - Drives busy to the hazard unit, which stalls later HI/LO users in D.
//   - Supports cancel so the pipeline can kill an in-flight operation on flush.

---
 rtl/md_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/md_sched.sv
// Multi-cycle HI/LO multiply/divide scheduler: models fixed mult/div latency,
// owns the architectural HI/LO registers and reports busy/done/drop to the pipeline.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue,
    input  logic [2:0]  op,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic        drop,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        busy_q, busy_d, done_q, done_d, drop_q, drop_d;

    // One shared unsigned divider; signed ops divide magnitudes and fix signs after.
    logic        is_sgn, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, quo_mag, rem_mag, quo, rem;
    logic [63:0] a_ext, b_ext, prod;

    assign is_sgn  = ~op_q[0];
    assign a_neg   = is_sgn & a_q[31];
    assign b_neg   = is_sgn & b_q[31];
    assign a_mag   = a_neg ? -a_q : a_q;
    assign b_mag   = b_neg ? -b_q : b_q;
    assign quo_mag = a_mag / b_mag;
    assign rem_mag = a_mag % b_mag;
    assign quo     = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
    assign rem     = a_neg ? -rem_mag : rem_mag;
    // Low 64 bits of the product of sign/zero-extended operands equal the exact result.
    assign a_ext   = {{32{a_neg}}, a_q};
    assign b_ext   = {{32{b_neg}}, b_q};
    assign prod    = a_ext * b_ext;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (issue && !cancel) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            state_d = StRun;
                            op_d    = op[1:0];
                            a_d     = d1;
                            b_d     = d2;
                            cnt_d   = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        end
                        3'd4:    hi_d   = d1;
                        3'd5:    lo_d   = d1;
                        default: drop_d = 1'b1;
                    endcase
                end
            end
            StRun: begin
                if (cancel) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    drop_d = issue;
                    if (cnt_q == 4'd1) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        if (!op_q[1]) begin
                            hi_d = prod[63:32];
                            lo_d = prod[31:0];
                        end else if (b_q != '0) begin
                            hi_d = rem;
                            lo_d = quo;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign drop = drop_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
